instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, the address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  when high, freezes all fetch state for the cycle.
REQ-005 SHALL have port instr_address  output  32  byte address driven to the instruction memory (combinational-read responder).
REQ-006 SHALL have port instr_readdata  input  32  word returned by the instruction memory in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  the current instruction is a taken branch or jump.
REQ-008 SHALL have port redirect_target  input  32  byte target of that branch or jump.
REQ-009 SHALL have port instr_word  output  32  instr_readdata forwarded to decode.
REQ-010 SHALL have port instr_pc  output  32  address of instr_word.
REQ-011 SHALL have port instr_valid  output  1  instr_word is consumed this cycle.
REQ-012 SHALL have port active  output  1  high until the halt sequence completes.
REQ-013 SHALL have port fault  output  2  sticky error flags: bit0 misaligned target, bit1 redirect in delay slot.
REQ-014 SHALL have port instr_count  output  32  number of instructions consumed since reset.

Function
REQ-015 SHALL hold a 32-bit PC register; instr_address = instr_pc = PC, and instr_word = instr_readdata, all combinational.
REQ-016 SHALL implement states RUN, DELAY and HALTED.
REQ-017 SHALL drive instr_valid = (state != HALTED) && !stall.
REQ-018 SHALL drive active = (state != HALTED).
REQ-019 SHALL leave PC, state, latched target, fault and instr_count unchanged on any edge where stall=1; redirect_valid SHALL be ignored while stall=1.
REQ-020 In RUN with redirect_valid=0, SHALL set PC <= PC+4, with 32-bit wrap-around.
REQ-021 In RUN with redirect_valid=1, SHALL latch redirect_target, set PC <= PC+4 (delay slot), and enter DELAY.
REQ-022 In DELAY, SHALL set PC <= latched target and return to RUN; if the latched target is 32'h0, SHALL instead enter HALTED with PC <= 0.
REQ-023 SHALL, if redirect_valid=1 in DELAY, ignore the new target, set fault[1], and otherwise act per REQ-022.
REQ-024 SHALL, if redirect_target[1:0] != 0 in RUN with redirect_valid=1, set fault[0], enter HALTED and leave PC unchanged.
REQ-025 In HALTED, SHALL hold PC and ignore all inputs except reset_n; HALTED SHALL be exit-only via reset.
REQ-026 SHALL increment instr_count by 1, modulo 2^32, on every edge where instr_valid=1.
REQ-027 SHALL give zero-latency fetch: one instruction per unstalled cycle and no bubble on redirect, because the delay slot covers the redirect.

Reset
REQ-028 SHALL, on reset_n low, immediately and asynchronously set PC=RESET_VECTOR, state=RUN, latched target=0, fault=0 and instr_count=0.
REQ-029 SHALL therefore show, after reset: instr_address=RESET_VECTOR, instr_valid=!stall, active=1.
REQ-030 SHALL let reset asserted in DELAY or HALTED discard any pending redirect, with no effect after release.
REQ-031 SHALL leave state unchanged on the first edge after reset_n release unless stall=0, in which case normal operation proceeds.

Verification
REQ-032 SHALL cover: reset release, 4 unstalled cycles -> instr_address 0xBFC00000, ..04, ..08, ..0C, ..10; instr_count=4.
REQ-033 SHALL cover: redirect_valid with target 0xBFC00100 at PC 0xBFC00008 -> next PCs 0xBFC0000C then 0xBFC00100; fault=0.
REQ-034 SHALL cover: redirect to 0x0 at PC 0xBFC00020 -> delay slot 0xBFC00024 consumed, then active=0, instr_valid=0, PC=0, instr_count frozen.
REQ-035 SHALL cover: stall high 3 cycles mid-run -> PC and instr_count unchanged, instr_valid=0; resume continues at PC+4.
REQ-036 SHALL cover: redirect target 0xBFC00102 -> fault=2'b01, HALTED, PC unchanged; redirect asserted in DELAY -> fault=2'b10, first target used.
REQ-037 SHALL cover: reset_n pulsed low asynchronously while in DELAY -> PC=0xBFC00000 immediately, state RUN, no jump to the latched target.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-issue PC sequencer with one branch delay slot,
// zero-address halt and sticky fault flags; instruction memory reads combinationally.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        active,
    output logic [1:0]  fault,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {RUN, DELAY, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] count_q, count_d;

    assign instr_address = pc_q;
    assign instr_pc      = pc_q;
    assign instr_word    = instr_readdata;
    assign active        = state_q != HALTED;
    assign instr_valid   = active && !stall;
    assign fault         = fault_q;
    assign instr_count   = count_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        fault_d  = fault_q;
        count_d  = instr_valid ? count_q + 32'd1 : count_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (redirect_valid && redirect_target[1:0] != 2'b00) begin
                        fault_d[0] = 1'b1;
                        state_d    = HALTED;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (redirect_valid) begin
                            target_d = redirect_target;
                            state_d  = DELAY;
                        end
                    end
                end
                DELAY: begin
                    // a second redirect inside the delay slot is dropped, only flagged
                    if (redirect_valid) fault_d[1] = 1'b1;
                    pc_d    = target_q;
                    state_d = (target_q == 32'h0) ? HALTED : RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_VECTOR;
            target_q <= 32'h0;
            fault_q  <= 2'b00;
            count_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end
endmodule
